// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module n_bit_serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Handshake: start is taken only on an edge where ready=1; done pulses for
  // one cycle after d/bout are loaded, and ready returns the cycle after that.
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          ai, bi, di, br_nx;
`ifdef SERIAL_SUB_OVF_EN
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ready   = 1'b0;
    done    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    ai    = a_q[0];
    bi    = b_q[0];
    di    = ai ^ bi ^ br_q;
    br_nx = (~ai & bi) | (~(ai ^ bi) & br_q);

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
`endif
        end
      end
      SHIFT: begin
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        res_d      = res_q >> 1;
        res_d[N-1] = di;
        br_d       = br_nx;
        cnt_d      = cnt_q + CW'(1);
        // The visible result only moves on the last bit, so it holds steady
        // while the next operation is still shifting.
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res_d;
          bout_d  = br_nx;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ di);
`endif
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
